mem_ctrl: RTL and testbench

//  Data-memory responder for the CPU's load/store path.
//  - Accepts one request per handshake: byte address, access width and store data.
//  - Performs little-endian byte/half/word accesses on an internal DEPTH x 32 RAM with byte-lane enables.
//  - Splits word-crossing (misaligned) accesses into two RAM phases.
//  - Returns load data (zero- or sign-extended) and a completion pulse.

---
 rtl/mem_ctrl_if.sv | 25 ++
 rtl/mem_ctrl.sv | 142 ++++++++++++++
 tb/tb_mem_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// Load/store request and response bundle between the CPU data path and mem_ctrl.
interface mem_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_width;
  logic              req_sext;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;

  modport master (
    output req_valid, req_we, req_width, req_sext, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_width, req_sext, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

// File: rtl/mem_ctrl.sv
// Data-memory responder: byte/half/word little-endian accesses on a DEPTH x 32 RAM,
// with word-crossing accesses split into two RAM phases.
module mem_ctrl #(
  parameter int    ADDR_W    = 10,
  parameter string INIT_FILE = ""
) (
  input  logic      clk,
  input  logic      rst_n,
  mem_ctrl_if.slave bus
);
  localparam int WA_W  = ADDR_W - 2;
  localparam int DEPTH = 2 ** WA_W;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t            state_r, state_s;
  logic              we_r, sext_r;
  logic [1:0]        width_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic [31:0]       lo_r, rd_r;
  logic [31:0]       mem [DEPTH];

  logic              accept_s, cross_s, ram_en_s;
  logic [7:0]        lane_base_s, lane_mask_s;
  logic [3:0]        ram_be_s;
  logic [WA_W-1:0]   w0_s, w1_s, ram_addr_s;
  logic [4:0]        shamt_s;
  logic [63:0]       rot_dbl_s, rd_dbl_s;
  logic [31:0]       rot_s, raw_s, ext_s, lo_s;

  assign accept_s  = bus.req_valid && (state_r == IDLE);
  assign w0_s      = addr_r[ADDR_W-1:2];
  assign w1_s      = w0_s + {{(WA_W-1){1'b0}}, 1'b1};
  assign shamt_s   = {addr_r[1:0], 3'b000};
  assign rot_dbl_s = {wdata_r, wdata_r} << shamt_s;
  assign rot_s     = rot_dbl_s[63:32];

  // Lane mask over an 8-lane window; lanes 4..7 belong to the following word.
  always_comb begin
    case (width_r)
      2'b00:   lane_base_s = 8'h01;
      2'b01:   lane_base_s = 8'h03;
      2'b10:   lane_base_s = 8'h0F;
      default: lane_base_s = 8'h00;
    endcase
    lane_mask_s = lane_base_s << addr_r[1:0];
    cross_s     = |lane_mask_s[7:4];
  end

  // Next-state and RAM phase control; reset suppresses any pending write edge.
  always_comb begin
    state_s    = state_r;
    ram_en_s   = 1'b0;
    ram_addr_s = w0_s;
    ram_be_s   = 4'b0000;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = (bus.req_width == 2'b11) ? RESP : ACC0;
        end else begin
          state_s = IDLE;
        end
      end
      ACC0: begin
        state_s    = cross_s ? ACC1 : RESP;
        ram_en_s   = rst_n;
        ram_addr_s = w0_s;
        ram_be_s   = lane_mask_s[3:0];
      end
      ACC1: begin
        state_s    = RESP;
        ram_en_s   = rst_n;
        ram_addr_s = w1_s;
        ram_be_s   = lane_mask_s[7:4];
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request capture on handshake, plus w0 read data held across ACC1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_r    <= 1'b0;
      sext_r  <= 1'b0;
      width_r <= 2'b00;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= 32'h0000_0000;
      lo_r    <= 32'h0000_0000;
    end else begin
      if (accept_s) begin
        we_r    <= bus.req_we;
        sext_r  <= bus.req_sext;
        width_r <= bus.req_width;
        addr_r  <= bus.req_addr;
        wdata_r <= bus.req_wdata;
      end
      if (state_r == ACC1) begin
        lo_r <= rd_r;
      end
    end
  end

  // RAM with byte-lane writes and registered read; contents are never reset.
  always_ff @(posedge clk) begin
    if (ram_en_s) begin
      for (int i = 0; i < 4; i++) begin
        if (we_r && ram_be_s[i]) begin
          mem[ram_addr_s][8*i +: 8] <= rot_s[8*i +: 8];
        end
      end
      rd_r <= mem[ram_addr_s];
    end
  end

  // Load assembly: realign the two-word window and extend to 32 bits.
  always_comb begin
    lo_s     = cross_s ? lo_r : rd_r;
    rd_dbl_s = {rd_r, lo_s} >> shamt_s;
    raw_s    = rd_dbl_s[31:0];
    case (width_r)
      2'b00:   ext_s = sext_r ? {{24{raw_s[7]}}, raw_s[7:0]} : {24'h000000, raw_s[7:0]};
      2'b01:   ext_s = sext_r ? {{16{raw_s[15]}}, raw_s[15:0]} : {16'h0000, raw_s[15:0]};
      default: ext_s = raw_s;
    endcase
  end

  assign bus.req_ready  = (state_r == IDLE);
  assign bus.resp_valid = (state_r == RESP);
  assign bus.resp_err   = (state_r == RESP) && (width_r == 2'b11);
  assign bus.resp_rdata = ((state_r == RESP) && !we_r && (width_r != 2'b11)) ? ext_s : 32'h0000_0000;
endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized bench for mem_ctrl against a byte-array reference memory.
module tb_mem_ctrl;
  localparam int ADDR_W = 10;
  localparam int NBYTES = 1 << ADDR_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  mem_ctrl #(.ADDR_W(ADDR_W), .INIT_FILE("")) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] model [NBYTES];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic int size_of(input logic [1:0] w);
    return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input int addr, input logic [1:0] w, input logic sext);
    logic [31:0] v;
    int n;
    v = 32'h0;
    n = size_of(w);
    for (int i = 0; i < n; i++) v = v | (32'(model[(addr + i) % NBYTES]) << (8 * i));
    if (sext && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic model_store(input int addr, input int nbytes, input logic [31:0] data);
    for (int i = 0; i < nbytes; i++) model[(addr + i) % NBYTES] = data[8*i +: 8];
  endtask

  task automatic do_op(input logic we, input logic [1:0] w, input logic sext, input int addr,
                       input logic [31:0] wdata, output logic [31:0] rdata);
    logic [31:0] exp_rd;
    int exp_lat, lat;
    bit seen;
    exp_rd  = (we || w == 2'b11) ? 32'h0 : model_load(addr, w, sext);
    exp_lat = (w == 2'b11) ? 1 : (((addr % 4) + size_of(w) > 4) ? 3 : 2);
    @(negedge clk);
    check_val("ready_idle", {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_width = w;
    bus.req_sext  = sext;
    bus.req_addr  = ADDR_W'(addr);
    bus.req_wdata = wdata;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    seen = 1'b0;
    lat  = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.resp_valid) begin
        seen = 1'b1;
        lat  = k + 1;
        break;
      end
      // junk store offered while busy must be ignored
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_width = 2'b10;
      bus.req_addr  = ADDR_W'($urandom);
      bus.req_wdata = $urandom;
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    rdata = bus.resp_rdata;
    if (!seen) begin
      check_val("resp_timeout", 32'd0, 32'd1);
    end else begin
      check_val($sformatf("latency@%03h w%0d", addr, w), 32'(lat), 32'(exp_lat));
      check_val($sformatf("err@%03h w%0d", addr, w), {31'b0, bus.resp_err}, {31'b0, (w == 2'b11)});
      check_val($sformatf("rdata@%03h w%0d s%0d we%0d", addr, w, sext, we), bus.resp_rdata, exp_rd);
      @(posedge clk);
      #1;
      check_val("pulse_one_cycle", {31'b0, bus.resp_valid}, 32'd0);
      check_val("ready_after_resp", {31'b0, bus.req_ready}, 32'd1);
    end
    if (we && w != 2'b11) model_store(addr, size_of(w), wdata);
  endtask

  initial begin
    logic [31:0] rd;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_width = 2'b00;
    bus.req_sext  = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ready", {31'b0, bus.req_ready}, 32'd1);
    check_val("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check_val("rst_resp_err", {31'b0, bus.resp_err}, 32'd0);
    check_val("rst_resp_rdata", bus.resp_rdata, 32'd0);
    rst_n = 1'b1;

    // fill the whole RAM so every later load has a known reference
    for (int wi = 0; wi < NBYTES / 4; wi++) do_op(1'b1, 2'b10, 1'b0, wi * 4, $urandom, rd);

    do_op(1'b1, 2'b10, 1'b0, 'h010, 32'hDEADBEEF, rd);
    do_op(1'b0, 2'b10, 1'b0, 'h010, 32'h0, rd);
    check_val("t1_word", rd, 32'hDEADBEEF);

    do_op(1'b1, 2'b10, 1'b0, 'h010, 32'h11223344, rd);
    do_op(1'b1, 2'b00, 1'b0, 'h013, 32'h000000A5, rd);
    do_op(1'b0, 2'b10, 1'b0, 'h010, 32'h0, rd);
    check_val("t2_word", rd, 32'hA5223344);
    do_op(1'b0, 2'b00, 1'b1, 'h013, 32'h0, rd);
    check_val("t2_sext", rd, 32'hFFFFFFA5);
    do_op(1'b0, 2'b00, 1'b0, 'h013, 32'h0, rd);
    check_val("t2_zext", rd, 32'h000000A5);

    do_op(1'b1, 2'b10, 1'b0, 'h02E, 32'h55667788, rd);
    do_op(1'b0, 2'b10, 1'b0, 'h02C, 32'h0, rd);
    check_val("t3_lo_word", {16'h0, rd[31:16]}, 32'h00007788);
    do_op(1'b0, 2'b10, 1'b0, 'h030, 32'h0, rd);
    check_val("t3_hi_word", {16'h0, rd[15:0]}, 32'h00005566);
    do_op(1'b0, 2'b10, 1'b0, 'h02E, 32'h0, rd);
    check_val("t3_cross", rd, 32'h55667788);

    do_op(1'b1, 2'b01, 1'b0, 'h3FF, 32'h0000BEEF, rd);
    do_op(1'b0, 2'b00, 1'b0, 'h3FF, 32'h0, rd);
    check_val("t4_top", rd, 32'h000000EF);
    do_op(1'b0, 2'b00, 1'b0, 'h000, 32'h0, rd);
    check_val("t4_wrap", rd, 32'h000000BE);
    do_op(1'b0, 2'b01, 1'b0, 'h3FF, 32'h0, rd);
    check_val("t4_half", rd, 32'h0000BEEF);

    do_op(1'b1, 2'b11, 1'b0, 'h040, 32'hCAFEF00D, rd);
    do_op(1'b0, 2'b10, 1'b0, 'h040, 32'h0, rd);

    // reset during ACC1 of a crossing store: only the w0 lanes land
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_width = 2'b10;
    bus.req_sext  = 1'b0;
    bus.req_addr  = ADDR_W'('h0FE);
    bus.req_wdata = 32'hA1B2C3D4;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_val("t6_no_resp", {31'b0, bus.resp_valid}, 32'd0);
    check_val("t6_ready", {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    check_val("t6_no_resp_late", {31'b0, bus.resp_valid}, 32'd0);
    model_store('h0FE, 2, 32'hA1B2C3D4);
    do_op(1'b0, 2'b10, 1'b0, 'h0FC, 32'h0, rd);
    do_op(1'b0, 2'b10, 1'b0, 'h100, 32'h0, rd);

    for (int n = 0; n < 400; n++) begin
      logic [1:0] w;
      w = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      do_op(1'($urandom), w, 1'($urandom), $urandom_range(0, NBYTES - 1), $urandom, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
